axil_periph_slave: RTL and testbench
====================================

// Module: axil_periph_slave
// PURPOSE
//  AXI4-Lite responder (slave end) for on-chip peripherals (UART, timers, mtimer) driven by the data-port mux.
//  Turns AXI write/read channel handshakes into single-cycle register strobes toward a peripheral register bank.
//  Returns read data and OKAY/SLVERR responses. One outstanding transaction; no bursts, no IDs.
// PARAMETERS
//  BASE_ADDR    32'h0  byte base address of this peripheral window
//  ADDR_W       4      word-index width; window = 2**ADDR_W 32-bit registers
//  READ_LAT     1      reg_rdata_i latency after reg_rd_o (0 = same cycle, 1 = next cycle)
// PORTS
//  clk_i        in   1       clock
//  rst_i        in   1       reset, asynchronous, active-high
//  awaddr_i     in   32      write address
//  awvalid_i    in   1       write address valid
//  awready_o    out  1       write address accepted
//  wdata_i      in   32      write data
//  wstrb_i      in   4       write byte strobes
//  wvalid_i     in   1       write data valid
//  wready_o     out  1       write data accepted
//  bresp_o      out  2       write response (00 OKAY, 10 SLVERR)
//  bvalid_o     out  1       write response valid
//  bready_i     in   1       write response taken
//  araddr_i     in   32      read address
//  arvalid_i    in   1       read address valid
//  arready_o    out  1       read address accepted
//  rdata_o      out  32      read data
//  rresp_o      out  2       read response
//  rvalid_o     out  1       read data valid
//  rready_i     in   1       read data taken
//  reg_addr_o   out  ADDR_W  register word index (addr[ADDR_W+1:2] - BASE word)
//  reg_wr_o     out  1       one-cycle register write strobe
//  reg_wdata_o  out  32      register write data
//  reg_wstrb_o  out  4       register byte enables
//  reg_rd_o     out  1       one-cycle register read strobe
//  reg_rdata_i  in   32      register read data
// BEHAVIOUR
//  Reset: state IDLE; all ready/valid/strobe outputs 0; rdata_o 0; bresp_o/rresp_o 00; rr_q 0. Mid-transaction reset aborts with no strobe and no response.
//  FSM: IDLE -> WRITE -> BRESP -> IDLE ; IDLE -> READ -> [RWAIT if READ_LAT=1] -> RRESP -> IDLE.
//  IDLE: write candidate = awvalid_i & wvalid_i (both required; either alone waits). Read candidate = arvalid_i.
//  Both candidates in same cycle: rr_q selects (0 = write first); rr_q toggles after each grant, so conflicts alternate.
//  WRITE (1 cycle): awready_o = wready_o = 1. reg_wr_o = 1 if address in range, with latched addr/data/strb. bresp latched: in range 00, else 10.
//  BRESP: bvalid_o = 1, held with bresp_o stable until bready_i; IDLE the cycle after bready_i.
//  READ (1 cycle): arready_o = 1. reg_rd_o = 1 if in range. READ_LAT=0: rdata_o <= reg_rdata_i at end of cycle.
//  RWAIT (READ_LAT=1 only): rdata_o <= reg_rdata_i.
//  RRESP: rvalid_o = 1, rdata_o/rresp_o held until rready_i. Out of range: rdata_o = 0, rresp_o = 10.
//  Latency, valids->response valid: write 2 cycles; read 2 (READ_LAT=0) or 3 (READ_LAT=1). Back-to-back throughput is one transaction per 3-4 cycles.
//  Range check: awaddr/araddr >= BASE_ADDR and < BASE_ADDR + 4*2**ADDR_W. Computed in 33 bits so the top of the address space does not wrap.
//  Address bits [1:0] are ignored. wstrb_i = 0 with valid address still produces reg_wr_o, with reg_wstrb_o = 0, and response OKAY.
//  Ready outputs are never asserted in BRESP/RRESP; new valids are held off until IDLE.
// STRUCTURE
//  Shared package axil_pkg: resp codes (AXI_OKAY=2'b00, AXI_SLVERR=2'b10), typedef enum axil_state_t {IDLE,WRITE,BRESP,READ,RWAIT,RRESP}.
//  One sub-module, axil_addr_decode: range check plus word-index extraction, instanced twice (aw and ar paths).
// TESTING
//  1 Write 0x1234_5678 to BASE+8, strb F -> reg_wr_o one cycle, reg_addr_o 2, bvalid 2 cycles after valids, bresp 00.
//  2 Read BASE+4, reg_rdata_i 0xCAFE_F00D, READ_LAT=1 -> reg_rd_o once, rvalid cycle 3 with rdata 0xCAFE_F00D, rresp 00.
//  3 Read BASE+4*2**ADDR_W (out of range) -> no reg_rd_o, rdata 0, rresp 10; write there -> no reg_wr_o, bresp 10.
//  4 awvalid, wvalid, arvalid all held high from reset -> write served first, then read; order alternates on repeat.
//  5 bready_i low 5 cycles -> bvalid and bresp stable 5 cycles, no new awready; rready_i=0 same check on read path.
//  6 rst_i asserted during RWAIT -> outputs 0 asynchronously, no rvalid after release, next read completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and responder FSM states.
package axil_pkg;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    BRESP = 3'd2,
    READ  = 3'd3,
    RWAIT = 3'd4,
    RRESP = 3'd5
  } axil_state_t;

endpackage

// File: rtl/axil_addr_decode.sv
// Window range check and register word-index extraction for one address channel.
module axil_addr_decode
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic [31:0]       addr_i,
  output logic              in_range_o,
  output logic [ADDR_W-1:0] idx_o
);

  logic [32:0] addr_ext;
  logic [32:0] base_ext;
  logic [32:0] limit_ext;

  // 33-bit compare keeps a window ending at 4 GiB from wrapping to zero.
  always_comb begin
    addr_ext   = {1'b0, addr_i};
    base_ext   = {1'b0, BASE_ADDR};
    limit_ext  = base_ext + (33'd4 << ADDR_W);
    in_range_o = (addr_ext >= base_ext) && (addr_ext < limit_ext);
    idx_o      = addr_i[ADDR_W+1:2] - BASE_ADDR[ADDR_W+1:2];
  end

endmodule

// File: rtl/axil_periph_slave.sv
// AXI4-Lite responder: converts single AXI transactions into one-cycle
// register strobes toward a peripheral register bank.
module axil_periph_slave
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [31:0]       araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic              reg_wr_o,
  output logic [31:0]       reg_wdata_o,
  output logic [3:0]        reg_wstrb_o,
  output logic              reg_rd_o,
  input  logic [31:0]       reg_rdata_i
);

  axil_state_t       state_q, state_d;
  logic              rr_q, rr_d;
  logic              hit_q, hit_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              aw_hit, ar_hit;
  logic [ADDR_W-1:0] aw_idx, ar_idx;
  logic              wr_cand, rd_cand;

  axil_addr_decode #(.BASE_ADDR(BASE_ADDR), .ADDR_W(ADDR_W)) u_aw_decode (
    .addr_i     (awaddr_i),
    .in_range_o (aw_hit),
    .idx_o      (aw_idx)
  );

  axil_addr_decode #(.BASE_ADDR(BASE_ADDR), .ADDR_W(ADDR_W)) u_ar_decode (
    .addr_i     (araddr_i),
    .in_range_o (ar_hit),
    .idx_o      (ar_idx)
  );

  assign wr_cand = awvalid_i & wvalid_i;
  assign rd_cand = arvalid_i;

  // Next-state, arbitration and capture of the granted transaction.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    hit_d   = hit_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    bresp_d = bresp_q;
    rresp_d = rresp_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (wr_cand && (!rd_cand || !rr_q)) begin
          state_d = WRITE;
          rr_d    = ~rr_q;
          hit_d   = aw_hit;
          addr_d  = aw_idx;
          wdata_d = wdata_i;
          wstrb_d = wstrb_i;
          bresp_d = aw_hit ? AXI_OKAY : AXI_SLVERR;
        end else if (rd_cand) begin
          state_d = READ;
          rr_d    = ~rr_q;
          hit_d   = ar_hit;
          addr_d  = ar_idx;
          rresp_d = ar_hit ? AXI_OKAY : AXI_SLVERR;
        end
      end
      WRITE: state_d = BRESP;
      BRESP: if (bready_i) state_d = IDLE;
      READ: begin
        if (READ_LAT == 0) begin
          rdata_d = hit_q ? reg_rdata_i : '0;
          state_d = RRESP;
        end else begin
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        rdata_d = hit_q ? reg_rdata_i : '0;
        state_d = RRESP;
      end
      RRESP: if (rready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-transaction registers; reset aborts any transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= AXI_OKAY;
      rresp_q <= AXI_OKAY;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hit_q   <= hit_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
    end
  end

  assign awready_o   = (state_q == WRITE);
  assign wready_o    = (state_q == WRITE);
  assign reg_wr_o    = (state_q == WRITE) & hit_q;
  assign bvalid_o    = (state_q == BRESP);
  assign bresp_o     = bresp_q;
  assign arready_o   = (state_q == READ);
  assign reg_rd_o    = (state_q == READ) & hit_q;
  assign rvalid_o    = (state_q == RRESP);
  assign rresp_o     = rresp_q;
  assign rdata_o     = rdata_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_axil_periph_slave.sv
// Directed self-checking bench for axil_periph_slave (BASE 0x4000_0000, 16 regs, READ_LAT 1).
module tb_axil_periph_slave;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] awaddr_i, wdata_i, araddr_i, reg_rdata_i;
  logic [31:0] rdata_o, reg_wdata_o;
  logic [3:0]  wstrb_i, reg_wstrb_o, reg_addr_o;
  logic [1:0]  bresp_o, rresp_o;
  logic        awvalid_i, wvalid_i, bready_i, arvalid_i, rready_i;
  logic        awready_o, wready_o, bvalid_o, arready_o, rvalid_o, reg_wr_o, reg_rd_o;

  int n_checks = 0;
  int n_fail   = 0;

  axil_periph_slave #(.BASE_ADDR(BASE), .ADDR_W(4), .READ_LAT(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .reg_addr_o(reg_addr_o), .reg_wr_o(reg_wr_o), .reg_wdata_o(reg_wdata_o),
    .reg_wstrb_o(reg_wstrb_o), .reg_rd_o(reg_rd_o), .reg_rdata_i(reg_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        output logic hs, output logic wr, output logic [3:0] idx,
                        output logic [31:0] wd, output logic [3:0] st,
                        output logic bv, output logic [1:0] resp);
    awaddr_i = addr; wdata_i = data; wstrb_i = strb; awvalid_i = 1'b1; wvalid_i = 1'b1;
    cyc();
    hs = awready_o & wready_o; wr = reg_wr_o; idx = reg_addr_o; wd = reg_wdata_o; st = reg_wstrb_o;
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    cyc();
    bv = bvalid_o; resp = bresp_o;
    bready_i = 1'b1;
    cyc();
    bready_i = 1'b0;
  endtask

  task automatic rd_txn(input logic [31:0] addr, input logic [31:0] rd_data,
                        output logic hs, output logic rd, output logic [3:0] idx, output logic early,
                        output logic rv, output logic [31:0] data, output logic [1:0] resp);
    araddr_i = addr; reg_rdata_i = rd_data; arvalid_i = 1'b1;
    cyc();
    hs = arready_o; rd = reg_rd_o; idx = reg_addr_o;
    arvalid_i = 1'b0;
    cyc();
    early = rvalid_o | reg_rd_o;
    cyc();
    rv = rvalid_o; data = rdata_o; resp = rresp_o;
    rready_i = 1'b1;
    cyc();
    rready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    awaddr_i = '0; wdata_i = '0; wstrb_i = '0; araddr_i = '0; reg_rdata_i = '0;
    awvalid_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0; arvalid_i = 1'b0; rready_i = 1'b0;
    cyc(); cyc();
    n_checks++;
    if ({awready_o, wready_o, bvalid_o, arready_o, rvalid_o, reg_wr_o, reg_rd_o, bresp_o, rresp_o} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected all zero",
               {awready_o, wready_o, bvalid_o, arready_o, rvalid_o, reg_wr_o, reg_rd_o, bresp_o, rresp_o});
    end
    n_checks++;
    if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
    rst_i = 1'b0;
    cyc();
  endtask

  task automatic test_write();
    awaddr_i = BASE + 32'h8; wdata_i = 32'h1234_5678; wstrb_i = 4'hF;
    awvalid_i = 1'b1; wvalid_i = 1'b1;
    cyc();
    n_checks++;
    if ({awready_o, wready_o, reg_wr_o, bvalid_o} !== 4'b1110) begin
      n_fail++; $display("FAIL wr_strobe_cycle: got %b expected 1110", {awready_o, wready_o, reg_wr_o, bvalid_o});
    end
    n_checks++;
    if ({reg_addr_o, reg_wstrb_o, reg_wdata_o} !== {4'd2, 4'hF, 32'h1234_5678}) begin
      n_fail++; $display("FAIL wr_reg_bus: got addr %h strb %h data %h expected 2 f 12345678",
                         reg_addr_o, reg_wstrb_o, reg_wdata_o);
    end
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    cyc();
    n_checks++;
    if ({bvalid_o, bresp_o, reg_wr_o, awready_o} !== 5'b10000) begin
      n_fail++; $display("FAIL wr_bresp: got %b expected 10000", {bvalid_o, bresp_o, reg_wr_o, awready_o});
    end
    bready_i = 1'b1;
    cyc();
    bready_i = 1'b0;
    n_checks++;
    if (bvalid_o !== 1'b0) begin n_fail++; $display("FAIL wr_bvalid_drop: got %b expected 0", bvalid_o); end
  endtask

  task automatic test_read();
    araddr_i = BASE + 32'h4; reg_rdata_i = 32'hCAFE_F00D; arvalid_i = 1'b1;
    cyc();
    n_checks++;
    if ({arready_o, reg_rd_o, rvalid_o, reg_addr_o} !== {3'b110, 4'd1}) begin
      n_fail++; $display("FAIL rd_strobe_cycle: got %b expected 1100001", {arready_o, reg_rd_o, rvalid_o, reg_addr_o});
    end
    arvalid_i = 1'b0;
    cyc();
    n_checks++;
    if ({arready_o, reg_rd_o, rvalid_o} !== 3'b000) begin
      n_fail++; $display("FAIL rd_wait_cycle: got %b expected 000", {arready_o, reg_rd_o, rvalid_o});
    end
    cyc();
    n_checks++;
    if ({rvalid_o, rresp_o, rdata_o} !== {1'b1, 2'b00, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL rd_resp: got rvalid %b rresp %b rdata %h expected 1 00 cafef00d", rvalid_o, rresp_o, rdata_o);
    end
    rready_i = 1'b1;
    cyc();
    rready_i = 1'b0;
    n_checks++;
    if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_drop: got %b expected 0", rvalid_o); end
  endtask

  task automatic test_out_of_range();
    logic hs, stb, early, v;
    logic [3:0] idx, st;
    logic [31:0] d;
    logic [1:0] resp;
    rd_txn(BASE + 32'h40, 32'h1357_9BDF, hs, stb, idx, early, v, d, resp);
    n_checks++;
    if ({hs, stb, early, v, resp, d} !== {4'b1001, 2'b10, 32'h0}) begin
      n_fail++; $display("FAIL rd_oor_top: got hs %b rd %b early %b rv %b resp %b data %h expected 1 0 0 1 10 0",
                         hs, stb, early, v, resp, d);
    end
    rd_txn(BASE - 32'h4, 32'h1357_9BDF, hs, stb, idx, early, v, d, resp);
    n_checks++;
    if ({hs, stb, v, resp, d} !== {3'b101, 2'b10, 32'h0}) begin
      n_fail++; $display("FAIL rd_oor_below: got hs %b rd %b rv %b resp %b data %h expected 1 0 1 10 0", hs, stb, v, resp, d);
    end
    rd_txn(BASE + 32'h3C, 32'h2468_ACE0, hs, stb, idx, early, v, d, resp);
    n_checks++;
    if ({hs, stb, idx, v, resp, d} !== {2'b11, 4'd15, 1'b1, 2'b00, 32'h2468_ACE0}) begin
      n_fail++; $display("FAIL rd_last_word: got hs %b rd %b idx %h rv %b resp %b data %h expected 1 1 f 1 00 2468ace0",
                         hs, stb, idx, v, resp, d);
    end
    wr_txn(BASE + 32'h40, 32'hDEAD_BEEF, 4'hF, hs, stb, idx, d, st, v, resp);
    n_checks++;
    if ({hs, stb, v, resp} !== {3'b101, 2'b10}) begin
      n_fail++; $display("FAIL wr_oor: got hs %b wr %b bv %b resp %b expected 1 0 1 10", hs, stb, v, resp);
    end
    wr_txn(BASE + 32'h3F, 32'h0BAD_F00D, 4'h0, hs, stb, idx, d, st, v, resp);
    n_checks++;
    if ({hs, stb, idx, st, d, v, resp} !== {2'b11, 4'd15, 4'h0, 32'h0BAD_F00D, 1'b1, 2'b00}) begin
      n_fail++; $display("FAIL wr_zero_strb: got hs %b wr %b idx %h strb %h data %h bv %b resp %b expected 1 1 f 0 0badf00d 1 00",
                         hs, stb, idx, st, d, v, resp);
    end
  endtask

  task automatic test_arbitration();
    logic g [4];
    int   n = 0;
    rst_i = 1'b1;
    awaddr_i = BASE; wdata_i = 32'h0000_00AA; wstrb_i = 4'hF; araddr_i = BASE + 32'h4;
    awvalid_i = 1'b1; wvalid_i = 1'b1; arvalid_i = 1'b1; bready_i = 1'b1; rready_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      cyc();
      if (awready_o) begin g[n] = 1'b1; n++; end
      else if (arready_o) begin g[n] = 1'b0; n++; end
    end
    n_checks++;
    if (n != 4) begin
      n_fail++; $display("FAIL arb_grants: got %0d grants expected 4 within 40 cycles", n);
    end else begin
      n_checks++;
      if ({g[0], g[1], g[2], g[3]} !== 4'b1010) begin
        n_fail++; $display("FAIL arb_order: got %b expected 1010 (1=write)", {g[0], g[1], g[2], g[3]});
      end
    end
    awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
    repeat (4) cyc();
    bready_i = 1'b0; rready_i = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    awaddr_i = BASE + 32'h80; wdata_i = 32'h5555_AAAA; wstrb_i = 4'h3;
    awvalid_i = 1'b1; wvalid_i = 1'b1;
    cyc();
    awaddr_i = BASE;
    cyc();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bvalid_o, bresp_o, awready_o, wready_o} !== 5'b11000) begin
        n_fail++; $display("FAIL b_stall_%0d: got %b expected 11000", i, {bvalid_o, bresp_o, awready_o, wready_o});
      end
      cyc();
    end
    awvalid_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b1;
    cyc();
    bready_i = 1'b0;
    n_checks++;
    if (bvalid_o !== 1'b0) begin n_fail++; $display("FAIL b_stall_release: got %b expected 0", bvalid_o); end

    araddr_i = BASE + 32'h8; reg_rdata_i = 32'h1111_2222; arvalid_i = 1'b1;
    cyc(); cyc(); cyc();
    reg_rdata_i = 32'h3333_4444;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rvalid_o, rresp_o, arready_o, rdata_o} !== {4'b1000, 32'h1111_2222}) begin
        n_fail++; $display("FAIL r_stall_%0d: got rv %b resp %b arready %b data %h expected 1 00 0 11112222",
                           i, rvalid_o, rresp_o, arready_o, rdata_o);
      end
      cyc();
    end
    arvalid_i = 1'b0; rready_i = 1'b1;
    cyc();
    rready_i = 1'b0;
    n_checks++;
    if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL r_stall_release: got %b expected 0", rvalid_o); end
  endtask

  task automatic test_reset_mid_read();
    logic hs, stb, early, v;
    logic [3:0] idx;
    logic [31:0] d;
    logic [1:0] resp;
    logic seen;
    araddr_i = BASE + 32'h4; reg_rdata_i = 32'hABCD_0123; arvalid_i = 1'b1;
    cyc();
    arvalid_i = 1'b0;
    cyc();
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if ({arready_o, reg_rd_o, rvalid_o, rresp_o, rdata_o} !== 37'h0) begin
      n_fail++; $display("FAIL rst_mid_async: got arready %b rd %b rv %b resp %b data %h expected all 0",
                         arready_o, reg_rd_o, rvalid_o, rresp_o, rdata_o);
    end
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      seen = seen | rvalid_o | reg_rd_o;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_resp: got %b expected 0", seen); end
    rd_txn(BASE + 32'hC, 32'h5A5A_A5A5, hs, stb, idx, early, v, d, resp);
    n_checks++;
    if ({hs, stb, idx, early, v, resp, d} !== {2'b11, 4'd3, 2'b01, 2'b00, 32'h5A5A_A5A5}) begin
      n_fail++; $display("FAIL rst_mid_next_read: got hs %b rd %b idx %h early %b rv %b resp %b data %h expected 1 1 3 0 1 00 5a5aa5a5",
                         hs, stb, idx, early, v, resp, d);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_arbitration();
    test_backpressure();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
